arbitro_escrita_reg: RTL and testbench
======================================

// Module: arbitro_escrita_reg
// PURPOSE
//  Shares the single write port of the 64x32 register file between two writeback
//  requesters: req 0 = ALU result, req 1 = memory/IO load result.
//  Round-robin arbitration with valid/ready handshakes and a registered output stage.
//  Flags read-after-write hazards against the write in flight.
//  Counts contention cycles for debug.
//  Sits between the writeback muxing and the register file write port.
// PARAMETERS
//  ADDR_W      6   register address width (64 registers)
//  DATA_W      32  write data width
//  PROTEGE_R0  0   1: accepted writes to address 0 are consumed but never drive reg_write
//  CONT_W      16  width of the saturating contention counter
// PORTS
//  clock          in   1       system clock; all state updates on posedge
//  reset_n        in   1       reset, asynchronous, active-low
//  pausa          in   1       1: no grants issued (both ready low); in-flight write still completes
//  valido0        in   1       req 0 has a write pending
//  pronto0        out  1       req 0 write accepted this cycle (combinational grant)
//  end0           in   ADDR_W  req 0 destination register
//  dado0          in   DATA_W  req 0 write data
//  valido1        in   1       req 1 has a write pending
//  pronto1        out  1       req 1 write accepted this cycle (combinational grant)
//  end1           in   ADDR_W  req 1 destination register
//  dado1          in   DATA_W  req 1 write data
//  reg_write      out  1       register file write enable (registered)
//  reg_escrita    out  ADDR_W  register file write address (registered)
//  escreve_dado   out  DATA_W  register file write data (registered)
//  leitura1       in   ADDR_W  register file read address 1 (for hazard check)
//  leitura2       in   ADDR_W  register file read address 2 (for hazard check)
//  hazard         out  1       a read address matches the write in flight (combinational)
//  contencao      out  CONT_W  saturating count of cycles with both requests valid and pausa=0
// BEHAVIOUR
//  Reset (async, while reset_n=0):
//   - reg_write=0, reg_escrita=0, escreve_dado=0, contencao=0, ultimo=1.
//   - pronto0=pronto1=0, forced combinationally.
//   - Reset mid-write drops the in-flight write: reg_write falls immediately.
//  Handshake: transfer on req i when valido_i && pronto_i at posedge; requester must
//   hold end_i/dado_i stable while valido_i=1 && pronto_i=0.
//  Grant (combinational; state register ultimo = last requester granted):
//   - pausa=1 or neither valid -> no grant.
//   - only one valid -> that requester granted.
//   - both valid -> the requester != ultimo granted (strict alternation).
//   - At most one of pronto0/pronto1 is high in any cycle.
//  Pointer: on a grant, ultimo <= granted index; otherwise unchanged.
//  Output stage, posedge N with grant:
//   - reg_escrita <= end, escreve_dado <= dado.
//   - reg_write <= 1, except 0 if PROTEGE_R0=1 and end=0.
//   - Register file commits at negedge of cycle N+1 (latency 1 cycle, half-cycle to commit).
//  No grant at posedge: reg_write <= 0; reg_escrita/escreve_dado hold previous values.
//  Throughput: one write per cycle, never stalls from the register file side.
//  hazard = reg_write && ((leitura1==reg_escrita) || (leitura2==reg_escrita)).
//   - Flags only the registered write in flight; pending unaccepted requests do not count.
//  contencao: +1 each posedge with valido0 && valido1 && !pausa; saturates at all-ones.
//  Same destination from both requesters in one cycle: ordered by arbitration;
//   loser writes next cycle, so the later write wins.
// TESTING
//  1. reset_n=0, then release -> all outputs 0; first cycle with both valid grants req 0.
//  2. Both valid for 4 cycles (end0=5, end1=9) -> pronto 0,1,0,1;
//     reg_escrita 5,9,5,9 one cycle later; contencao=4.
//  3. Only req 1 valid for 3 cycles, data 0xA,0xB,0xC to reg 7 ->
//     pronto1 high every cycle; reg 7 reads 0xC after the last negedge.
//  4. pausa=1 with both valid -> no pronto, reg_write=0 from next cycle, contencao unchanged;
//     drop pausa -> alternation resumes from the stored ultimo.
//  5. Grant write to reg 12, leitura1=12 next cycle -> hazard=1 for one cycle only;
//     PROTEGE_R0=1, write to reg 0 -> pronto high, reg_write stays 0.
//  6. Assert reset_n=0 mid-stream with reg_write=1 -> reg_write and pronto drop at once;
//     force contencao to all-ones -> it stays there.

Source files
------------

// File: rtl/arbitro_escrita_reg_if.sv
// Writeback bus between the two requesters, the register file write port and the hazard check.
// master = requester/read side, slave = arbiter.
`timescale 1ns/1ps
interface arbitro_escrita_reg_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int CONT_W = 16
);
  logic              pausa;
  logic              valido0;
  logic              pronto0;
  logic [ADDR_W-1:0] end0;
  logic [DATA_W-1:0] dado0;
  logic              valido1;
  logic              pronto1;
  logic [ADDR_W-1:0] end1;
  logic [DATA_W-1:0] dado1;
  logic              reg_write;
  logic [ADDR_W-1:0] reg_escrita;
  logic [DATA_W-1:0] escreve_dado;
  logic [ADDR_W-1:0] leitura1;
  logic [ADDR_W-1:0] leitura2;
  logic              hazard;
  logic [CONT_W-1:0] contencao;

  modport master (
    output pausa, valido0, end0, dado0, valido1, end1, dado1, leitura1, leitura2,
    input  pronto0, pronto1, reg_write, reg_escrita, escreve_dado, hazard, contencao
  );

  modport slave (
    input  pausa, valido0, end0, dado0, valido1, end1, dado1, leitura1, leitura2,
    output pronto0, pronto1, reg_write, reg_escrita, escreve_dado, hazard, contencao
  );
endinterface

// File: rtl/arbitro_escrita_reg.sv
// Round-robin arbiter for the single register-file write port (req 0 = ALU, req 1 = load),
// registered write stage, RAW hazard flag against the write in flight, contention counter.
`timescale 1ns/1ps
module arbitro_escrita_reg #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter bit PROTEGE_R0 = 1'b0,
  parameter int CONT_W     = 16
) (
  input logic                 clock,
  input logic                 reset_n,
  arbitro_escrita_reg_if.slave bus
);
  localparam int NUM_REQ = 2;
  localparam int NUM_RD  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dado;
  } req_t;

  typedef enum logic {ULT_0 = 1'b0, ULT_1 = 1'b1} ultimo_t;

  req_t [NUM_REQ-1:0]              req;
  logic [NUM_REQ-1:0]              valido;
  logic [NUM_REQ-1:0]              pronto;
  logic [NUM_RD-1:0][ADDR_W-1:0]   leit;
  logic [NUM_RD-1:0]               match;
  ultimo_t                         ultimo, ultimo_nxt;
  req_t                            sel;
  logic                            grant;
  logic                            we_nxt;

  logic                            reg_write_q;
  logic [ADDR_W-1:0]               reg_escrita_q;
  logic [DATA_W-1:0]               escreve_dado_q;
  logic [CONT_W-1:0]               contencao_q;

  assign valido = {bus.valido1, bus.valido0};
  assign req[0] = '{addr: bus.end0, dado: bus.dado0};
  assign req[1] = '{addr: bus.end1, dado: bus.dado1};
  assign leit   = {bus.leitura2, bus.leitura1};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ultimo <= ULT_1;
    else          ultimo <= ultimo_nxt;
  end

  // Grant is gated by reset_n so both ready lines are low while reset is held.
  always_comb begin
    pronto     = '0;
    ultimo_nxt = ultimo;
    if (reset_n && !bus.pausa) begin
      if (&valido) pronto = (ultimo == ULT_1) ? 2'b01 : 2'b10;
      else         pronto = valido;
    end
    if (pronto[0])      ultimo_nxt = ULT_0;
    else if (pronto[1]) ultimo_nxt = ULT_1;
  end

  assign grant  = |pronto;
  assign sel    = pronto[1] ? req[1] : req[0];
  // A protected write to r0 is still consumed (ready high) but never enables the port.
  assign we_nxt = !(PROTEGE_R0 && (sel.addr == '0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_q    <= 1'b0;
      reg_escrita_q  <= '0;
      escreve_dado_q <= '0;
    end else if (grant) begin
      reg_write_q    <= we_nxt;
      reg_escrita_q  <= sel.addr;
      escreve_dado_q <= sel.dado;
    end else begin
      reg_write_q    <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      contencao_q <= '0;
    else if ((&valido) && !bus.pausa && (contencao_q != '1))
      contencao_q <= contencao_q + CONT_W'(1);
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign match[i] = (leit[i] == reg_escrita_q);
  end

  assign bus.pronto0      = pronto[0];
  assign bus.pronto1      = pronto[1];
  assign bus.reg_write    = reg_write_q;
  assign bus.reg_escrita  = reg_escrita_q;
  assign bus.escreve_dado = escreve_dado_q;
  assign bus.hazard       = reg_write_q && (|match);
  assign bus.contencao    = contencao_q;
endmodule

// File: tb/tb_arbitro_escrita_reg.sv
// Bench for arbitro_escrita_reg: vector table with write scoreboard, then reset/r0/saturation sequences.
`timescale 1ns/1ps
module tb_arbitro_escrita_reg;
  logic clock = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  arbitro_escrita_reg_if #(.ADDR_W(6), .DATA_W(32), .CONT_W(16)) a ();
  arbitro_escrita_reg_if #(.ADDR_W(6), .DATA_W(32), .CONT_W(3))  b ();

  arbitro_escrita_reg #(.ADDR_W(6), .DATA_W(32), .PROTEGE_R0(1'b0), .CONT_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(a.slave));
  arbitro_escrita_reg #(.ADDR_W(6), .DATA_W(32), .PROTEGE_R0(1'b1), .CONT_W(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(b.slave));

  typedef struct packed {
    logic        pausa, v0, v1;
    logic [5:0]  e0;
    logic [31:0] d0;
    logic [5:0]  e1;
    logic [31:0] d1;
    logic [5:0]  l1, l2;
    logic        p0, p1;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rf [64];
  logic        m_we;
  logic [5:0]  m_addr;
  logic [31:0] m_data;
  logic [15:0] m_cnt;

  // Register file sink: commits on the negedge following the registered write.
  always @(negedge clock) if (a.reg_write) rf[a.reg_escrita] <= a.escreve_dado;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pausa, v0, v1, input logic [5:0] e0, input logic [31:0] d0,
                              input logic [5:0] e1, input logic [31:0] d1,
                              input logic [5:0] l1, l2, input logic p0, p1);
    vec_t v;
    v.pausa = pausa; v.v0 = v0; v.v1 = v1; v.e0 = e0; v.d0 = d0; v.e1 = e1; v.d1 = d1;
    v.l1 = l1; v.l2 = l2; v.p0 = p0; v.p1 = p1;
    return v;
  endfunction

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    a.pausa = v.pausa; a.valido0 = v.v0; a.valido1 = v.v1;
    a.end0 = v.e0; a.dado0 = v.d0; a.end1 = v.e1; a.dado1 = v.d1;
    a.leitura1 = v.l1; a.leitura2 = v.l2;
    @(negedge clock);
    chk($sformatf("v%0d pronto0", idx), a.pronto0, v.p0);
    chk($sformatf("v%0d pronto1", idx), a.pronto1, v.p1);
    chk($sformatf("v%0d hazard", idx), a.hazard, m_we && ((v.l1 == m_addr) || (v.l2 == m_addr)));
    if (v.p0)      sb.push_back('{we: 1'b1, addr: v.e0, data: v.d0});
    else if (v.p1) sb.push_back('{we: 1'b1, addr: v.e1, data: v.d1});
    else           sb.push_back('{we: 1'b0, addr: m_addr, data: m_data});
    if (v.v0 && v.v1 && !v.pausa && m_cnt != 16'hffff) m_cnt++;
    @(posedge clock); #1;
    if (sb.size() == 0) begin
      chk($sformatf("v%0d scoreboard", idx), 1, 0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d reg_write", idx), a.reg_write, e.we);
      chk($sformatf("v%0d reg_escrita", idx), a.reg_escrita, e.addr);
      chk($sformatf("v%0d escreve_dado", idx), a.escreve_dado, e.data);
      m_we = e.we; m_addr = e.addr; m_data = e.data;
    end
    chk($sformatf("v%0d contencao", idx), a.contencao, m_cnt);
  endtask

  vec_t tbl[16];

  initial begin
    // both valid, alternating from reset
    tbl[0]  = mk(0,1,1, 6'd5, 32'h50, 6'd9, 32'h90, 6'd63, 6'd63, 1,0);
    tbl[1]  = mk(0,1,1, 6'd5, 32'h51, 6'd9, 32'h90, 6'd63, 6'd63, 0,1);
    tbl[2]  = mk(0,1,1, 6'd5, 32'h51, 6'd9, 32'h91, 6'd63, 6'd63, 1,0);
    tbl[3]  = mk(0,1,1, 6'd5, 32'h52, 6'd9, 32'h91, 6'd63, 6'd63, 0,1);
    // only req 1 streaming into reg 7
    tbl[4]  = mk(0,0,1, 6'd0, 32'h0,  6'd7, 32'hA,  6'd63, 6'd63, 0,1);
    tbl[5]  = mk(0,0,1, 6'd0, 32'h0,  6'd7, 32'hB,  6'd63, 6'd63, 0,1);
    tbl[6]  = mk(0,0,1, 6'd0, 32'h0,  6'd7, 32'hC,  6'd63, 6'd63, 0,1);
    // paused, then resume from stored pointer (last grant = 1)
    tbl[7]  = mk(1,1,1, 6'd3, 32'h33, 6'd4, 32'h44, 6'd63, 6'd63, 0,0);
    tbl[8]  = mk(1,1,1, 6'd3, 32'h33, 6'd4, 32'h44, 6'd63, 6'd63, 0,0);
    tbl[9]  = mk(0,1,1, 6'd3, 32'h33, 6'd4, 32'h44, 6'd63, 6'd63, 1,0);
    tbl[10] = mk(0,1,1, 6'd3, 32'h35, 6'd4, 32'h44, 6'd63, 6'd63, 0,1);
    // hazard on reg 12 for one cycle, second read port also checked
    tbl[11] = mk(0,1,0, 6'd12,32'h12, 6'd0, 32'h0,  6'd63, 6'd63, 1,0);
    tbl[12] = mk(0,0,0, 6'd0, 32'h0,  6'd0, 32'h0,  6'd1,  6'd12, 0,0);
    tbl[13] = mk(0,0,0, 6'd0, 32'h0,  6'd0, 32'h0,  6'd12, 6'd12, 0,0);
    // same destination from both: loser (req 0) writes later and wins
    tbl[14] = mk(0,1,1, 6'd20,32'h111,6'd20,32'h222, 6'd63, 6'd63, 0,1);
    tbl[15] = mk(0,1,0, 6'd20,32'h111,6'd0, 32'h0,   6'd63, 6'd63, 1,0);
  end

  initial begin
    m_we = 1'b0; m_addr = '0; m_data = '0; m_cnt = '0;
    reset_n = 1'b0;
    a.pausa = 0; a.valido0 = 1; a.valido1 = 1; a.end0 = 0; a.dado0 = 0;
    a.end1 = 0; a.dado1 = 0; a.leitura1 = 0; a.leitura2 = 0;
    b.pausa = 0; b.valido0 = 0; b.valido1 = 0; b.end0 = 0; b.dado0 = 0;
    b.end1 = 0; b.dado1 = 0; b.leitura1 = 0; b.leitura2 = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset pronto0", a.pronto0, 0);
    chk("reset pronto1", a.pronto1, 0);
    chk("reset reg_write", a.reg_write, 0);
    chk("reset reg_escrita", a.reg_escrita, 0);
    chk("reset escreve_dado", a.escreve_dado, 0);
    chk("reset contencao", a.contencao, 0);
    chk("reset hazard", a.hazard, 0);
    a.valido0 = 0; a.valido1 = 0;
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 16; i++) step(tbl[i], i);
    step(mk(0,0,0, 6'd0, 32'h0, 6'd0, 32'h0, 6'd63, 6'd63, 0,0), 16);
    chk("rf[7]", rf[7], 32'hC);
    chk("rf[20]", rf[20], 32'h111);
    chk("rf[12]", rf[12], 32'h12);

    // reset in the middle of a write
    a.valido0 = 1; a.valido1 = 1; a.end0 = 6'd33; a.end1 = 6'd34;
    @(posedge clock); #1;
    chk("pre-reset reg_write", a.reg_write, 1);
    reset_n = 1'b0;
    #1;
    chk("mid reset reg_write", a.reg_write, 0);
    chk("mid reset pronto0", a.pronto0, 0);
    chk("mid reset pronto1", a.pronto1, 0);
    chk("mid reset contencao", a.contencao, 0);
    a.valido0 = 0; a.valido1 = 0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // protected r0 on dut_b
    b.valido0 = 1; b.end0 = 6'd0; b.dado0 = 32'hDEAD;
    @(negedge clock);
    chk("r0 pronto0", b.pronto0, 1);
    @(posedge clock); #1;
    chk("r0 reg_write", b.reg_write, 0);
    b.end0 = 6'd3; b.dado0 = 32'hBEEF;
    @(negedge clock);
    chk("r3 pronto0", b.pronto0, 1);
    @(posedge clock); #1;
    chk("r3 reg_write", b.reg_write, 1);
    chk("r3 reg_escrita", b.reg_escrita, 3);
    chk("r3 escreve_dado", b.escreve_dado, 32'hBEEF);

    // saturation of the 3-bit counter
    b.valido1 = 1; b.end1 = 6'd4;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      chk($sformatf("sat k=%0d", k), b.contencao, (k > 7) ? 7 : k);
    end
    b.valido0 = 0; b.valido1 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
